// File: rtl/explore_gen_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the exploration generator.
// The LFSR step and the epsilon decay live here so every user applies the same rule.
package explore_gen_pkg;

    localparam logic [31:0] LFSR_MASK32   = 32'h80200003;
    localparam logic [31:0] LFSR_ZERO_SUB = 32'hACE1ACE1;
    localparam int          ACT_W         = 2;

    typedef enum logic {
        ST_DECAY = 1'b0,
        ST_FLOOR = 1'b1
    } state_t;

    // A one-step period still needs a one-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int unsigned period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        return (r >> 1) ^ (r[0] ? LFSR_MASK32 : 32'h0);
    endfunction

    // The minimum decrement of one guarantees progress toward the floor even for tiny epsilon.
    function automatic logic [15:0] eps_decay(input logic [15:0] eps,
                                              input logic [15:0] eps_min,
                                              input int unsigned shift);
        logic [15:0] d;
        logic [15:0] e;
        d = eps >> shift;
        if (d == 16'h0) d = 16'h1;
        e = eps - d;
        return (e < eps_min) ? eps_min : e;
    endfunction

endpackage

// File: rtl/explore_gen_if.sv
// Control and result bundle between the exploration generator and the policy generator.
// The master side issues decision steps; the slave side returns the drawn actions.
interface explore_gen_if;
    import explore_gen_pkg::*;

    logic             learning;
    logic             step;
    logic             eps_reload;
    logic [ACT_W-1:0] Arand_A;
    logic [ACT_W-1:0] Arand_B;
    logic             Asel_A;
    logic             Asel_B;
    logic             act_valid;
    logic [15:0]      epsilon;
    logic             eps_floor;

    modport master (
        output learning, step, eps_reload,
        input  Arand_A, Arand_B, Asel_A, Asel_B, act_valid, epsilon, eps_floor
    );

    modport slave (
        input  learning, step, eps_reload,
        output Arand_A, Arand_B, Asel_A, Asel_B, act_valid, epsilon, eps_floor
    );

endinterface

// File: rtl/explore_gen_lfsr32_galois.sv
// 32-bit Galois LFSR advancing one position per adv pulse.
// A zero seed is swapped for a fixed non-zero constant so the register can never lock up.
module lfsr32_galois
    import explore_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] q
);

    logic [31:0] seed_eff;

    assign seed_eff = (seed == 32'h0) ? LFSR_ZERO_SUB : seed;

    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed_eff;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/explore_gen.sv
// Exploration input generator: two LFSR action draws per step, compared against a shared
// epsilon that decays every DECAY_PERIOD learning steps until it settles at EPS_MIN.
module explore_gen
    import explore_gen_pkg::*;
#(
    parameter logic [31:0] SEED_A       = 32'h1D872B41,
    parameter logic [31:0] SEED_B       = 32'h7F4A7C15,
    parameter logic [15:0] EPS_INIT     = 16'hE666,
    parameter logic [15:0] EPS_MIN      = 16'h0CCC,
    parameter int unsigned DECAY_PERIOD = 16,
    parameter int unsigned DECAY_SHIFT  = 4
) (
    input logic       clk,
    input logic       rst,
    explore_gen_if.slave bus
);

    localparam int               CNT_W     = cnt_width(DECAY_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DECAY_PERIOD - 1);
    localparam state_t           RST_STATE = (EPS_INIT <= EPS_MIN) ? ST_FLOOR : ST_DECAY;

    logic [31:0]      lfsr_a;
    logic [31:0]      lfsr_b;
    logic [31:0]      draw_a;
    logic [31:0]      draw_b;
    logic [15:0]      epsilon;
    logic [15:0]      epsilon_next;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_cnt_next;
    state_t           state;
    state_t           state_next;
    logic             qualify;

    lfsr32_galois u_lfsr_a (.clk(clk), .rst(rst), .seed(SEED_A), .adv(bus.step), .q(lfsr_a));
    lfsr32_galois u_lfsr_b (.clk(clk), .rst(rst), .seed(SEED_B), .adv(bus.step), .q(lfsr_b));

    // Draws use the value the LFSRs are about to load, so outputs match the new LFSR state.
    assign draw_a  = lfsr_next(lfsr_a);
    assign draw_b  = lfsr_next(lfsr_b);
    assign qualify = bus.step & bus.learning & (state == ST_DECAY);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        epsilon_next  = epsilon;
        step_cnt_next = step_cnt;
        state_next    = state;
        if (bus.eps_reload) begin
            epsilon_next  = EPS_INIT;
            step_cnt_next = '0;
            state_next    = RST_STATE;
        end else if (state == ST_FLOOR) begin
            step_cnt_next = '0;
        end else if (qualify) begin
            if (step_cnt == CNT_LAST) begin
                step_cnt_next = '0;
                epsilon_next  = eps_decay(epsilon, EPS_MIN, DECAY_SHIFT);
                if (epsilon_next == EPS_MIN) state_next = ST_FLOOR;
            end else begin
                step_cnt_next = step_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epsilon  <= EPS_INIT;
            step_cnt <= '0;
            state    <= RST_STATE;
        end else begin
            epsilon  <= epsilon_next;
            step_cnt <= step_cnt_next;
            state    <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Arand_A   <= '0;
            bus.Arand_B   <= '0;
            bus.Asel_A    <= 1'b0;
            bus.Asel_B    <= 1'b0;
            bus.act_valid <= 1'b0;
        end else begin
            bus.act_valid <= bus.step;
            if (bus.step) begin
                bus.Arand_A <= draw_a[16 +: ACT_W];
                bus.Arand_B <= draw_b[16 +: ACT_W];
                bus.Asel_A  <= (draw_a[15:0] > epsilon);
                bus.Asel_B  <= (draw_b[15:0] > epsilon);
            end
        end
    end

    assign bus.epsilon   = epsilon;
    assign bus.eps_floor = (state == ST_FLOOR);

endmodule
